// File: rtl/line_burst_reader.sv
// Cache-line burst reader: walks one line of a combinational-read RAM and emits it as a valid/ready burst.
// Optional critical-word-first ordering is enabled by defining LINE_BURST_READER_CRIT_WORD_FIRST_EN.
module line_burst_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] req_line,
  input  logic [OFFSET_WIDTH-1:0]          req_offset,
  output logic [ADDR_WIDTH-1:0]            raddr,
  input  logic [DATA_WIDTH-1:0]            rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic                             busy
);

  localparam int LINE_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;
  localparam logic [OFFSET_WIDTH:0] LAST_SENT = {1'b0, {OFFSET_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [LINE_WIDTH-1:0]   base_q;
  logic [OFFSET_WIDTH-1:0] cnt_q;
  logic [OFFSET_WIDTH:0]   sent_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;

  logic [OFFSET_WIDTH-1:0] cnt_d;
  logic [OFFSET_WIDTH:0]   sent_d;
  logic [OFFSET_WIDTH-1:0] start_cnt_d;
  logic                    slot_free_s;

  assign cnt_d       = cnt_q + OFFSET_WIDTH'(1'b1);
  assign sent_d      = sent_q + (OFFSET_WIDTH + 1)'(1'b1);
  assign slot_free_s = !out_valid_q || out_ready;

`ifdef LINE_BURST_READER_CRIT_WORD_FIRST_EN
  assign start_cnt_d = req_offset;
`else
  logic unused_offset_s;
  assign unused_offset_s = ^req_offset;
  assign start_cnt_d     = {OFFSET_WIDTH{1'b0}};
`endif

  // Burst FSM: address walk, output slot and last-word tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      base_q      <= {LINE_WIDTH{1'b0}};
      cnt_q       <= {OFFSET_WIDTH{1'b0}};
      sent_q      <= {(OFFSET_WIDTH + 1){1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            base_q  <= req_line;
            cnt_q   <= start_cnt_d;
            sent_q  <= {(OFFSET_WIDTH + 1){1'b0}};
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          // Last-word detection uses the word count, not the address, so wrap order still ends correctly
          if (slot_free_s) begin
            out_data_q  <= rdata;
            out_valid_q <= 1'b1;
            out_last_q  <= (sent_q == LAST_SENT);
            cnt_q       <= cnt_d;
            sent_q      <= sent_d;
            if (sent_q == LAST_SENT) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign raddr     = {base_q, cnt_q};
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_line_burst_reader.sv
// Directed bench for line_burst_reader: RAM holds mem[a] = 0xA000 + a, bursts are checked word by word.
module tb_line_burst_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [AW-OW-1:0] req_line;
  logic [OW-1:0] req_offset;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;

  assign rdata = mem[raddr];

  always #5 clk = ~clk;

  line_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_offset(req_offset), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input string tag, input logic [6:0] line, input logic [2:0] off);
    logic [2:0] idx;
    req_line   = line;
    req_offset = off;
    req_valid  = 1'b1;
    out_ready  = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_valid_e0"}, {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef LINE_BURST_READER_CRIT_WORD_FIRST_EN
      idx = off + 3'(i);
`else
      idx = 3'(i);
`endif
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, out_data, 32'hA000 + {22'd0, line, idx});
      chk({tag, "_last"}, {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_end_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hA000 + 32'(a);
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_line   = 7'd0;
    req_offset = 3'd0;
    out_ready  = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_raddr", {22'd0, raddr}, 32'd0);
    chk("idle_last", {31'd0, out_last}, 32'd0);
    chk("idle_data", out_data, 32'd0);

    run_burst("full", 7'd5, 3'd0);

    // Backpressure after word 2 for three cycles
    req_line = 7'd5; req_offset = 3'd0; req_valid = 1'b1; out_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pre_data", out_data, 32'hA028 + 32'(i));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, 32'hA02A);
      chk("bp_hold_raddr", {22'd0, raddr}, 32'h02B);
      chk("bp_hold_last", {31'd0, out_last}, 32'd0);
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tick();
      chk("bp_post_data", out_data, 32'hA028 + 32'(i));
      chk("bp_post_last", {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_end_req_ready", {31'd0, req_ready}, 32'd1);

    // Request pulse while busy must be dropped
    req_line = 7'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("ign_w1", out_data, 32'hA029);
    req_line = 7'd7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("ign_w2", out_data, 32'hA02A);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    for (int i = 3; i < 8; i++) begin
      tick();
      chk("ign_data", out_data, 32'hA028 + 32'(i));
    end
    tick();
    chk("ign_end_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("ign_not_queued_busy", {31'd0, busy}, 32'd0);
    chk("ign_not_queued_valid", {31'd0, out_valid}, 32'd0);
    run_burst("line7", 7'd7, 3'd3);

    // Asynchronous reset in the middle of a burst
    req_line = 7'd5; req_offset = 3'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ar_w3", out_data, 32'hA02B);
    chk("ar_w3_valid", {31'd0, out_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_raddr", {22'd0, raddr}, 32'd0);
    chk("ar_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    resetn = 1'b1;
    #1;
    run_burst("after_rst", 7'd5, 3'd0);

    run_burst("crit", 7'd5, 3'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
